tank_unit: RTL and testbench
============================

# tank_unit

Parametrised second-generation player/tank controller for the artillery game. It replaces the fixed-constant player block with configurable geometry, speeds and limits. It adds an integrated movement-tick divider, a turn gate, a fire-release pulse and a terminal DEAD state. It sits between the keyboard decoder / terrain-collision unit and the renderer / projectile launcher, one instance per player.

## Interface
- POS_W, 18, width of object_x/object_y
- BOARD_X, 18'h20000 / BOARD_Y, 18'h18000, playfield size; legal coordinates are 0..BOARD-1
- INIT_X, 0 / INIT_Y, 0 / INIT_DIR, 0, reset position and facing (0 = left, 1 = right)
- WALK_V, 32 / CLIMB_V, 32 / DROP_V, 48, pixels moved per movement tick
- TICK_DIV, 4, clock cycles per movement tick (≥1)
- ANG_W, 8 / ANGLE_STEP, 16 / ANGLE_MAX, 144, angle register width, step and ceiling
- PWR_W, 8 / POWER_STEP, 16 / POWER_MAX, 240, power register width, step and ceiling
- HP_W, 8 / HEALTH_INIT, 128 / HIT_LOSS, 32, health register width, start value and damage per hit
- clock  in  1  system clock
- rst_n  in  1  reset, synchronous, active-low; clock clock
- active  in  1  1 = this player's turn
- keyboard_input  in  7  [6:5] edge code: 01 = press, 11 = hold, 10 = release, 00 = none; [4:0] one-hot command: 10000 = fwd (right), 01000 = back (left), 00100 = angle up, 00010 = angle down, 00001 = fire
- collision  in  4  [3] above blocked, [2] support below, [1] left blocked, [0] right blocked
- hit  in  1  one-cycle damage strobe
- object_x, object_y  out  POS_W  position; y grows downward
- direction  out  1  facing
- angle  out  ANG_W  barrel angle
- power  out  PWR_W  current charge
- fire  out  1  one-cycle launch pulse
- fire_power  out  PWR_W  charge latched at the last fire
- health  out  HP_W  remaining health
- alive  out  1  0 in DEAD
- mode  out  3  state code: IDLE = 0, WALK = 1, CLIMB = 2, FALL = 3, DEAD = 4

## Operation
- Reset values:
  - x = INIT_X, y = INIT_Y, direction = INIT_DIR.
  - angle = power = fire_power = 0, fire = 0.
  - health = HEALTH_INIT, alive = 1, mode = IDLE, tick counter = 0.
- tick: the counter counts 0..TICK_DIV-1 and tick asserts on TICK_DIV-1. The counter runs in every state except DEAD.
- IDLE:
  - collision[2] = 0 → FALL. This has priority over keys.
  - Else, when active, on press of fwd/back: set direction (fwd = 1, back = 0). Facing side blocked and above free → CLIMB. Facing side free → WALK. Otherwise stay in IDLE.
  - Angle up/down on press or hold: saturating ±ANGLE_STEP within 0..ANGLE_MAX, computed at ANG_W+1 bits.
- Fire charge: active and fire press/hold → power = min(power + POWER_STEP, POWER_MAX). Allowed in IDLE only.
- Fire release: on fire release, fire = 1 for one cycle, fire_power ← power, power ← 0.
- WALK:
  - Release → IDLE.
  - No support → FALL.
  - Facing side blocked → CLIMB if above is free, else IDLE.
  - On tick: x ± WALK_V.
- CLIMB:
  - Above blocked → IDLE.
  - Facing side clear → WALK if the code is hold, else IDLE.
  - On tick: y − CLIMB_V.
- FALL: support → IDLE; on tick: y + DROP_V.
- active drops to 0:
  - WALK/CLIMB → IDLE next cycle.
  - FALL continues.
  - power ← 0 with no fire.
- Bounds:
  - Every move is computed at POS_W+1 bits.
  - A result < 0 or > BOARD-1 leaves the position unchanged, sets health = 0 and enters DEAD.
- hit: health = max(health − HIT_LOSS, 0). If the result is 0 → DEAD.
- DEAD: all outputs frozen, fire = 0, all inputs ignored. Only reset exits.

## Timing
- Key, collision and hit responses are registered: they take effect one clock after sampling.
- Position changes only on tick cycles. A state change and a tick in the same cycle use the old state's velocity.
- Simultaneous events:
  - Hit and out-of-bounds in the same cycle → health 0, DEAD.
  - Fire release in the cycle that enters DEAD → no fire pulse.
  - Press of fwd with no support → FALL; the key is dropped.
- Reset mid-motion restores all reset values on the next edge.

## Test plan
- Reset, collision = 0100, fwd press then hold for 8 ticks → direction 1, mode WALK, x = 8 × 32 = 256.
- Walk right, then collision[0] = 1 with above free → CLIMB. After 2 ticks y decreases by 64. Set collision[3] → IDLE.
- collision = 0000 from IDLE → FALL; y + 48 per tick. collision[2] = 1 → IDLE.
- Angle up held for 12 cycles → angle saturates at 144. Angle down from 8 → 0.
- Fire hold for 20 cycles → power 240. Release → single fire pulse, fire_power = 240, power = 0. Repeat with active = 0 → no change.
- 4 hits → health 0, DEAD, alive 0. Further keys ignored. Separately, walk left from x = 16 → health 0, DEAD, x stays 16.

Source files
------------

// File: rtl/tank_unit.sv
// rtl/tank_unit.sv - parametrised player/tank controller: movement FSM, tick divider, aim, charge/fire, health
module tank_unit #(
    parameter int POS_W       = 18,
    parameter int BOARD_X     = 18'h20000,
    parameter int BOARD_Y     = 18'h18000,
    parameter int INIT_X      = 0,
    parameter int INIT_Y      = 0,
    parameter int INIT_DIR    = 0,
    parameter int WALK_V      = 32,
    parameter int CLIMB_V     = 32,
    parameter int DROP_V      = 48,
    parameter int TICK_DIV    = 4,
    parameter int ANG_W       = 8,
    parameter int ANGLE_STEP  = 16,
    parameter int ANGLE_MAX   = 144,
    parameter int PWR_W       = 8,
    parameter int POWER_STEP  = 16,
    parameter int POWER_MAX   = 240,
    parameter int HP_W        = 8,
    parameter int HEALTH_INIT = 128,
    parameter int HIT_LOSS    = 32
) (
    input  logic             clock,
    input  logic             rst_n,
    input  logic             active,
    input  logic [6:0]       keyboard_input,
    input  logic [3:0]       collision,
    input  logic             hit,
    output logic [POS_W-1:0] object_x,
    output logic [POS_W-1:0] object_y,
    output logic             direction,
    output logic [ANG_W-1:0] angle,
    output logic [PWR_W-1:0] power,
    output logic             fire,
    output logic [PWR_W-1:0] fire_power,
    output logic [HP_W-1:0]  health,
    output logic             alive,
    output logic [2:0]       mode
);

    localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WALK  = 3'd1,
        ST_CLIMB = 3'd2,
        ST_FALL  = 3'd3,
        ST_DEAD  = 3'd4
    } state_t;

    state_t           state_q, state_d, state_nxt;
    logic [POS_W-1:0] x_q, x_d, y_q, y_d;
    logic             dir_q, dir_d, dir_nxt;
    logic [ANG_W-1:0] angle_q, angle_d;
    logic [PWR_W-1:0] power_q, power_d, fire_power_q, fire_power_d;
    logic             fire_q, fire_d;
    logic [HP_W-1:0]  health_q, health_d, hit_health;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [1:0] key_code;
    logic [4:0] key_cmd;
    logic       k_press, k_hold, k_release, k_press_or_hold;
    logic       cmd_fwd, cmd_back, cmd_up, cmd_down, cmd_fire;
    logic       tick, face_blk, idle_keys;
    logic       move_x, move_y, oob, die;
    logic [POS_W:0] x_move, y_move;
    logic [ANG_W:0] ang_up, ang_dn;
    logic [PWR_W:0] pwr_up;

    assign key_code        = keyboard_input[6:5];
    assign key_cmd         = keyboard_input[4:0];
    assign k_press         = (key_code == 2'b01);
    assign k_hold          = (key_code == 2'b11);
    assign k_release       = (key_code == 2'b10);
    assign k_press_or_hold = k_press || k_hold;
    assign cmd_fwd         = (key_cmd == 5'b10000);
    assign cmd_back        = (key_cmd == 5'b01000);
    assign cmd_up          = (key_cmd == 5'b00100);
    assign cmd_down        = (key_cmd == 5'b00010);
    assign cmd_fire        = (key_cmd == 5'b00001);

    assign tick      = (cnt_q == CNT_W'(TICK_DIV - 1));
    assign face_blk  = dir_q ? collision[0] : collision[1];
    assign idle_keys = (state_q == ST_IDLE) && collision[2] && active;

    assign ang_up = {1'b0, angle_q} + (ANG_W+1)'(ANGLE_STEP);
    assign ang_dn = {1'b0, angle_q} - (ANG_W+1)'(ANGLE_STEP);
    assign pwr_up = {1'b0, power_q} + (PWR_W+1)'(POWER_STEP);

    assign hit_health = (health_q > HP_W'(HIT_LOSS)) ? (health_q - HP_W'(HIT_LOSS)) : '0;

    // Movement uses the current (old) state's velocity. A negative result wraps
    // into the extra top bit, so one upper-bound compare also catches underflow.
    always_comb begin
        move_x = 1'b0;
        move_y = 1'b0;
        x_move = {1'b0, x_q};
        y_move = {1'b0, y_q};
        case (state_q)
            ST_WALK: begin
                move_x = tick;
                x_move = dir_q ? ({1'b0, x_q} + (POS_W+1)'(WALK_V))
                               : ({1'b0, x_q} - (POS_W+1)'(WALK_V));
            end
            ST_CLIMB: begin
                move_y = tick;
                y_move = {1'b0, y_q} - (POS_W+1)'(CLIMB_V);
            end
            ST_FALL: begin
                move_y = tick;
                y_move = {1'b0, y_q} + (POS_W+1)'(DROP_V);
            end
            default: ;
        endcase
        oob = (move_x && (x_move > (POS_W+1)'(BOARD_X - 1))) ||
              (move_y && (y_move > (POS_W+1)'(BOARD_Y - 1)));
    end

    always_comb begin
        state_nxt = state_q;
        dir_nxt   = dir_q;
        case (state_q)
            ST_IDLE: begin
                if (!collision[2]) begin
                    state_nxt = ST_FALL;
                end else if (active && k_press && (cmd_fwd || cmd_back)) begin
                    dir_nxt = cmd_fwd;
                    if (!(cmd_fwd ? collision[0] : collision[1])) begin
                        state_nxt = ST_WALK;
                    end else if (!collision[3]) begin
                        state_nxt = ST_CLIMB;
                    end
                end
            end
            ST_WALK: begin
                if (!active) begin
                    state_nxt = ST_IDLE;
                end else if (k_release && (cmd_fwd || cmd_back)) begin
                    state_nxt = ST_IDLE;
                end else if (!collision[2]) begin
                    state_nxt = ST_FALL;
                end else if (face_blk) begin
                    state_nxt = collision[3] ? ST_IDLE : ST_CLIMB;
                end
            end
            ST_CLIMB: begin
                if (!active || collision[3]) begin
                    state_nxt = ST_IDLE;
                end else if (!face_blk) begin
                    state_nxt = k_hold ? ST_WALK : ST_IDLE;
                end
            end
            ST_FALL: begin
                if (collision[2]) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d      = state_q;
        x_d          = x_q;
        y_d          = y_q;
        dir_d        = dir_q;
        angle_d      = angle_q;
        power_d      = power_q;
        fire_power_d = fire_power_q;
        fire_d       = 1'b0;
        health_d     = health_q;
        cnt_d        = cnt_q;
        die          = 1'b0;
        if (state_q != ST_DEAD) begin
            cnt_d = tick ? '0 : (cnt_q + CNT_W'(1));
            die   = oob || (hit && (hit_health == '0));
            if (die) begin
                // Entering DEAD freezes everything else, including a pending fire release.
                state_d  = ST_DEAD;
                health_d = '0;
            end else begin
                state_d = state_nxt;
                dir_d   = dir_nxt;
                if (hit) begin
                    health_d = hit_health;
                end
                if (move_x) begin
                    x_d = x_move[POS_W-1:0];
                end
                if (move_y) begin
                    y_d = y_move[POS_W-1:0];
                end
                if (idle_keys && k_press_or_hold && cmd_up) begin
                    angle_d = (ang_up > (ANG_W+1)'(ANGLE_MAX)) ? ANG_W'(ANGLE_MAX) : ang_up[ANG_W-1:0];
                end else if (idle_keys && k_press_or_hold && cmd_down) begin
                    angle_d = ang_dn[ANG_W] ? '0 : ang_dn[ANG_W-1:0];
                end
                if (!active) begin
                    power_d = '0;
                end else if (idle_keys && k_press_or_hold && cmd_fire) begin
                    power_d = (pwr_up > (PWR_W+1)'(POWER_MAX)) ? PWR_W'(POWER_MAX) : pwr_up[PWR_W-1:0];
                end else if (k_release && cmd_fire) begin
                    fire_d       = 1'b1;
                    fire_power_d = power_q;
                    power_d      = '0;
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            x_q          <= POS_W'(INIT_X);
            y_q          <= POS_W'(INIT_Y);
            dir_q        <= (INIT_DIR != 0);
            angle_q      <= '0;
            power_q      <= '0;
            fire_power_q <= '0;
            fire_q       <= 1'b0;
            health_q     <= HP_W'(HEALTH_INIT);
            cnt_q        <= '0;
        end else begin
            state_q      <= state_d;
            x_q          <= x_d;
            y_q          <= y_d;
            dir_q        <= dir_d;
            angle_q      <= angle_d;
            power_q      <= power_d;
            fire_power_q <= fire_power_d;
            fire_q       <= fire_d;
            health_q     <= health_d;
            cnt_q        <= cnt_d;
        end
    end

    assign object_x   = x_q;
    assign object_y   = y_q;
    assign direction  = dir_q;
    assign angle      = angle_q;
    assign power      = power_q;
    assign fire       = fire_q;
    assign fire_power = fire_power_q;
    assign health     = health_q;
    assign alive      = (state_q != ST_DEAD);
    assign mode       = state_q;

endmodule

// File: tb/tb_tank_unit.sv
// tb/tb_tank_unit.sv - scoreboard bench for tank_unit
module tb_tank_unit;

    localparam int POS_W = 18;
    localparam int IX    = 16;
    localparam int IY    = 1024;

    localparam logic [1:0] KP = 2'b01;
    localparam logic [1:0] KH = 2'b11;
    localparam logic [1:0] KR = 2'b10;
    localparam logic [4:0] FWD  = 5'b10000;
    localparam logic [4:0] BACK = 5'b01000;
    localparam logic [4:0] UP   = 5'b00100;
    localparam logic [4:0] DOWN = 5'b00010;
    localparam logic [4:0] FIRE = 5'b00001;

    localparam int S_X = 0, S_Y = 1, S_DIR = 2, S_ANG = 3, S_PWR = 4,
                   S_FIRE = 5, S_FP = 6, S_HP = 7, S_ALIVE = 8, S_MODE = 9;

    logic             clock = 1'b0;
    logic             rst_n;
    logic             active;
    logic [6:0]       keyboard_input;
    logic [3:0]       collision;
    logic             hit;
    logic [POS_W-1:0] object_x, object_y;
    logic             direction;
    logic [7:0]       angle, power, fire_power, health;
    logic             fire, alive;
    logic [2:0]       mode;

    int tests_run    = 0;
    int tests_failed = 0;

    typedef struct {
        string  tag;
        int     sel;
        longint val;
    } exp_t;
    exp_t sb[$];

    tank_unit #(.INIT_X(IX), .INIT_Y(IY)) dut (
        .clock(clock), .rst_n(rst_n), .active(active),
        .keyboard_input(keyboard_input), .collision(collision), .hit(hit),
        .object_x(object_x), .object_y(object_y), .direction(direction),
        .angle(angle), .power(power), .fire(fire), .fire_power(fire_power),
        .health(health), .alive(alive), .mode(mode)
    );

    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input longint got, input longint exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic longint obs(input int sel);
        case (sel)
            S_X:     return longint'(object_x);
            S_Y:     return longint'(object_y);
            S_DIR:   return longint'(direction);
            S_ANG:   return longint'(angle);
            S_PWR:   return longint'(power);
            S_FIRE:  return longint'(fire);
            S_FP:    return longint'(fire_power);
            S_HP:    return longint'(health);
            S_ALIVE: return longint'(alive);
            default: return longint'(mode);
        endcase
    endfunction

    task automatic expect_out(input string tag, input int sel, input longint val);
        sb.push_back('{tag, sel, val});
    endtask

    task automatic drain();
        exp_t e;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            check_eq(e.tag, obs(e.sel), e.val);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic do_reset(input logic [3:0] col);
        rst_n          = 1'b0;
        active         = 1'b1;
        keyboard_input = 7'd0;
        collision      = col;
        hit            = 1'b0;
        step(2);
        rst_n = 1'b1;
    endtask

    initial begin
        do_reset(4'b0100);
        expect_out("rst_x", S_X, IX);
        expect_out("rst_y", S_Y, IY);
        expect_out("rst_dir", S_DIR, 0);
        expect_out("rst_angle", S_ANG, 0);
        expect_out("rst_power", S_PWR, 0);
        expect_out("rst_fire", S_FIRE, 0);
        expect_out("rst_fp", S_FP, 0);
        expect_out("rst_health", S_HP, 128);
        expect_out("rst_alive", S_ALIVE, 1);
        expect_out("rst_mode", S_MODE, 0);
        drain();

        // Walk right 8 ticks, then climb against a right wall
        keyboard_input = {KP, FWD};
        step(1);
        expect_out("walk_mode0", S_MODE, 1);
        expect_out("walk_dir", S_DIR, 1);
        drain();
        keyboard_input = {KH, FWD};
        step(31);
        expect_out("walk_x", S_X, IX + 8 * 32);
        expect_out("walk_mode", S_MODE, 1);
        drain();
        collision = 4'b0101;
        step(1);
        expect_out("climb_enter", S_MODE, 2);
        expect_out("climb_x_hold", S_X, IX + 256);
        drain();
        step(7);
        expect_out("climb_y", S_Y, IY - 64);
        drain();
        collision = 4'b1101;
        step(1);
        expect_out("climb_exit", S_MODE, 0);
        expect_out("climb_y_hold", S_Y, IY - 64);
        drain();

        // Fall with a fwd press: the key is dropped
        do_reset(4'b0000);
        keyboard_input = {KP, FWD};
        step(1);
        expect_out("fall_enter", S_MODE, 3);
        expect_out("fall_keydrop_dir", S_DIR, 0);
        drain();
        keyboard_input = 7'd0;
        step(3);
        expect_out("fall_y1", S_Y, IY + 48);
        drain();
        step(4);
        expect_out("fall_y2", S_Y, IY + 96);
        drain();
        collision = 4'b0100;
        step(1);
        expect_out("fall_land", S_MODE, 0);
        drain();

        // Angle saturation both ways
        do_reset(4'b0100);
        keyboard_input = {KP, UP};
        step(1);
        expect_out("ang_first", S_ANG, 16);
        drain();
        keyboard_input = {KH, UP};
        step(11);
        expect_out("ang_max", S_ANG, 144);
        drain();
        keyboard_input = {KP, DOWN};
        step(1);
        keyboard_input = {KH, DOWN};
        step(2);
        expect_out("ang_down", S_ANG, 96);
        drain();
        step(7);
        expect_out("ang_min", S_ANG, 0);
        drain();

        // Charge, release, then release with active low
        do_reset(4'b0100);
        keyboard_input = {KP, FIRE};
        step(1);
        keyboard_input = {KH, FIRE};
        step(19);
        expect_out("pwr_max", S_PWR, 240);
        expect_out("pwr_nofire", S_FIRE, 0);
        drain();
        keyboard_input = {KR, FIRE};
        step(1);
        expect_out("fire_pulse", S_FIRE, 1);
        expect_out("fire_fp", S_FP, 240);
        expect_out("fire_pwr0", S_PWR, 0);
        drain();
        keyboard_input = 7'd0;
        step(1);
        expect_out("fire_single", S_FIRE, 0);
        drain();
        keyboard_input = {KP, FIRE};
        step(1);
        keyboard_input = {KH, FIRE};
        step(4);
        expect_out("pwr_80", S_PWR, 80);
        drain();
        active         = 1'b0;
        keyboard_input = {KR, FIRE};
        step(1);
        expect_out("inact_fire", S_FIRE, 0);
        expect_out("inact_pwr", S_PWR, 0);
        expect_out("inact_fp", S_FP, 240);
        drain();

        // Four hits kill; DEAD ignores inputs
        do_reset(4'b0100);
        for (int i = 0; i < 4; i++) begin
            hit = 1'b1;
            step(1);
            hit = 1'b0;
            expect_out($sformatf("hit_hp%0d", i), S_HP, 128 - 32 * (i + 1));
            drain();
        end
        expect_out("hit_alive", S_ALIVE, 0);
        expect_out("hit_mode", S_MODE, 4);
        drain();
        keyboard_input = {KP, FWD};
        step(2);
        keyboard_input = {KH, UP};
        step(6);
        expect_out("dead_x", S_X, IX);
        expect_out("dead_dir", S_DIR, 0);
        expect_out("dead_ang", S_ANG, 0);
        expect_out("dead_mode", S_MODE, 4);
        drain();

        // Walk left off the board edge
        do_reset(4'b0100);
        keyboard_input = {KP, BACK};
        step(1);
        keyboard_input = {KH, BACK};
        step(2);
        expect_out("oob_pre_mode", S_MODE, 1);
        expect_out("oob_pre_x", S_X, IX);
        drain();
        step(1);
        expect_out("oob_x", S_X, IX);
        expect_out("oob_hp", S_HP, 0);
        expect_out("oob_mode", S_MODE, 4);
        expect_out("oob_alive", S_ALIVE, 0);
        drain();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
